// File: rtl/pdm_cic_decimator.sv
// 1-bit PDM to signed PCM: 3rd-order CIC decimator, saturating rescale,
// and a one-entry valid/ready output slice with sticky overrun flag.
module pdm_cic_decimator #(
  parameter int DEC_RATIO = 64,
  parameter int OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pdm_en,
  input  logic                    pdm_in,
  output logic signed [OUT_W-1:0] pcm_out,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    settled,
  output logic                    overrun
);

  localparam int LOG2R = $clog2(DEC_RATIO);
  localparam int ACC_W = 3 * LOG2R + 2;
  localparam int SHIFT = 3 * LOG2R + 1 - OUT_W;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic [LOG2R-1:0]        count;
  logic signed [ACC_W-1:0] i1, i2, i3;
  logic signed [ACC_W-1:0] i1_new, i2_new, i3_new;
  logic signed [ACC_W-1:0] step;
  logic signed [ACC_W-1:0] p1, p2, p3;
  logic signed [ACC_W-1:0] c1, c2, c3;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] sat_val;
  logic signed [OUT_W-1:0] y;
  logic                    v1, v2, v3, v4;
  logic [1:0]              loads;
  logic                    tick;

  // +1 for a one bit, -1 (all ones) for a zero bit.
  assign step   = {{(ACC_W-1){~pdm_in}}, 1'b1};
  assign i1_new = i1 + step;
  assign i2_new = i2 + i1_new;
  assign i3_new = i3 + i2_new;
  assign tick   = pdm_en && (count == LOG2R'(DEC_RATIO - 1));

  assign shifted = c3 >>> SHIFT;

  always_comb begin
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SAT_HI)      sat_val = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) sat_val = SAT_LO[OUT_W-1:0];
  end

  // NOTE: all state uses non-blocking assignments so every stage samples the
  // previous stage's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      i1 <= '0; i2 <= '0; i3 <= '0;
      p1 <= '0; p2 <= '0; p3 <= '0;
      c1 <= '0; c2 <= '0; c3 <= '0;
      y  <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
    end else begin
      if (pdm_en) begin
        i1    <= i1_new;
        i2    <= i2_new;
        i3    <= i3_new;
        count <= count + LOG2R'(1);
      end
      // Comb delays advance only when their stage carries a decimated sample.
      v1 <= tick;
      if (tick) begin
        c1 <= i3_new - p1;
        p1 <= i3_new;
      end
      v2 <= v1;
      if (v1) begin
        c2 <= c1 - p2;
        p2 <= c1;
      end
      v3 <= v2;
      if (v2) begin
        c3 <= c2 - p3;
        p3 <= c2;
      end
      v4 <= v3;
      if (v3) y <= sat_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      settled   <= 1'b0;
      overrun   <= 1'b0;
      loads     <= 2'd0;
    end else if (v4) begin
      pcm_out   <= y;
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready) overrun <= 1'b1;
      if (loads != 2'd3)           loads   <= loads + 2'd1;
      if (loads == 2'd2)           settled <= 1'b1;
    end else if (pcm_valid && pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

endmodule
